// File: rtl/mem_arb_pkg.sv
// Shared state/owner encodings for the memory port arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} arb_state_t;
  typedef enum logic {OWN_FETCH, OWN_DATA} arb_owner_t;
endpackage

// File: rtl/arb_timeout_counter.sv
// Counts ACCESS cycles without mem_ready; tc flags the last cycle before abort.
// Holds at terminal count so it never wraps; cleared outside ACCESS.
module arb_timeout_counter #(
  parameter int timeout = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);
  localparam int CW = (timeout > 1) ? $clog2(timeout) : 1;
  localparam logic [CW-1:0] LAST = CW'(timeout - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !tc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store; min 3 cycles/access.
// Requesters hold req until done; streak limit stops data from starving fetch.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int word_size  = 32,
  parameter int addr_size  = 16,
  parameter int max_streak = 4,
  parameter int timeout    = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [addr_size-1:0] if_addr,
  output logic [word_size-1:0] if_rdata,
  output logic                 if_done,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [addr_size-1:0] d_addr,
  input  logic [word_size-1:0] d_wdata,
  output logic [word_size-1:0] d_rdata,
  output logic                 d_done,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [addr_size-1:0] mem_addr,
  output logic [word_size-1:0] mem_wdata,
  input  logic [word_size-1:0] mem_rdata,
  input  logic                 mem_ready,
  output logic                 err,
  input  logic                 err_clr,
  output logic                 busy
);
  localparam int SW = $clog2(max_streak + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(max_streak);

  arb_state_t           state_q, state_d;
  arb_owner_t           owner_q, owner_d;
  logic [SW-1:0]        streak_q, streak_d;
  logic                 mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [addr_size-1:0] mem_addr_q, mem_addr_d;
  logic [word_size-1:0] mem_wdata_q, mem_wdata_d;
  logic [word_size-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic                 if_done_q, if_done_d, d_done_q, d_done_d;
  logic                 err_q, err_d, busy_q, busy_d;
  logic                 grant_data;
  logic                 tmo_tc;

  arb_timeout_counter #(.timeout(timeout)) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q != ARB_ACCESS),
    .enable ((state_q == ARB_ACCESS) && !mem_ready),
    .tc     (tmo_tc)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    busy_d      = busy_q;
    err_d       = err_q & ~err_clr;
    grant_data  = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (if_req || d_req) begin
          // Data wins contention until it has used up its streak allowance.
          grant_data = d_req && (!if_req || (streak_q != STREAK_MAX));
          mem_en_d   = 1'b1;
          busy_d     = 1'b1;
          state_d    = ARB_ACCESS;
          if (grant_data) begin
            owner_d     = OWN_DATA;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            if (if_req && (streak_q != STREAK_MAX)) begin
              streak_d = streak_q + SW'(1);
            end
          end else begin
            owner_d     = OWN_FETCH;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            streak_d    = '0;
          end
        end
      end
      ARB_ACCESS: begin
        if (mem_ready || tmo_tc) begin
          mem_en_d = 1'b0;
          state_d  = ARB_RESP;
          if (owner_q == OWN_FETCH) begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_ready ? mem_rdata : '0;
          end else begin
            d_done_d = 1'b1;
            if (!mem_ready) begin
              d_rdata_d = '0;
            end else if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
          end
          if (!mem_ready) begin
            err_d = 1'b1;
          end
        end
      end
      ARB_RESP: begin
        busy_d  = 1'b0;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_FETCH;
      streak_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_done   = if_done_q;
  assign d_rdata   = d_rdata_q;
  assign d_done    = d_done_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; inputs change and outputs are sampled 1ns after each rising edge.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, mem_ready, err_clr;
  logic [15:0] if_addr, d_addr;
  logic [31:0] d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_wdata;
  logic        if_done, d_done, mem_en, mem_we, err, busy;
  logic [15:0] mem_addr;

  int nvec = 0;
  int nerr = 0;
  int cnt;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .err(err), .err_clr(err_clr), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; if_req = 0; d_req = 0; d_we = 0; mem_ready = 0; err_clr = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    #2 rst = 1'b0;
    #10;
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    step();
    rst = 1'b1;

    // Lone fetch, zero wait; mem_ready already high in IDLE must be ignored.
    if_req = 1; if_addr = 16'h0010; mem_rdata = 32'h98000000; mem_ready = 1;
    step();
    chk("f_mem_en", 32'(mem_en), 32'd1);
    chk("f_mem_addr", 32'(mem_addr), 32'h0010);
    chk("f_mem_we", 32'(mem_we), 32'd0);
    chk("f_busy", 32'(busy), 32'd1);
    chk("f_if_done_early", 32'(if_done), 32'd0);
    step();
    chk("f_if_done", 32'(if_done), 32'd1);
    chk("f_if_rdata", if_rdata, 32'h98000000);
    chk("f_d_done", 32'(d_done), 32'd0);
    chk("f_mem_en_off", 32'(mem_en), 32'd0);
    if_req = 0; mem_ready = 0;
    step();
    chk("f_if_done_pulse", 32'(if_done), 32'd0);
    chk("f_busy_idle", 32'(busy), 32'd0);

    // Load, zero wait, to give d_rdata a known non-zero value.
    d_req = 1; d_we = 0; d_addr = 16'h0044; mem_rdata = 32'hCAFEF00D; mem_ready = 1;
    step();
    chk("ld_mem_addr", 32'(mem_addr), 32'h0044);
    step();
    chk("ld_d_done", 32'(d_done), 32'd1);
    chk("ld_d_rdata", d_rdata, 32'hCAFEF00D);
    d_req = 0; mem_ready = 0;
    step();

    // Store with two wait cycles.
    d_req = 1; d_we = 1; d_addr = 16'h0040; d_wdata = 32'hDEADBEEF; mem_rdata = 32'h12345678;
    step();
    chk("st_mem_we", 32'(mem_we), 32'd1);
    chk("st_mem_addr", 32'(mem_addr), 32'h0040);
    chk("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
    step();
    chk("st_mem_en_w1", 32'(mem_en), 32'd1);
    chk("st_d_done_w1", 32'(d_done), 32'd0);
    step();
    chk("st_mem_en_w2", 32'(mem_en), 32'd1);
    mem_ready = 1;
    step();
    chk("st_d_done", 32'(d_done), 32'd1);
    chk("st_d_rdata_kept", d_rdata, 32'hCAFEF00D);
    chk("st_mem_en_off", 32'(mem_en), 32'd0);
    d_req = 0; d_we = 0; mem_ready = 0;
    step();

    // Contention: D,D,D,D,F repeating; reset lands in ACCESS of grant 14.
    if_req = 1; if_addr = 16'h0100; d_req = 1; d_addr = 16'h0200;
    mem_rdata = 32'h11111111; mem_ready = 1;
    for (int i = 0; i < 14; i++) begin
      step();
      chk($sformatf("grant_%0d", i), 32'(mem_addr), (i % 5 == 4) ? 32'h0100 : 32'h0200);
      if (i < 13) begin
        step();
        chk($sformatf("grant_done_%0d", i), {30'd0, if_done, d_done},
            (i % 5 == 4) ? 32'd2 : 32'd1);
        step();
      end
    end
    chk("rm_mem_en_pre", 32'(mem_en), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rm_mem_en", 32'(mem_en), 32'd0);
    chk("rm_busy", 32'(busy), 32'd0);
    chk("rm_done", {30'd0, if_done, d_done}, 32'd0);
    #2 rst = 1'b1;
    // Streak is back to 0, so data wins the next contended grant.
    step();
    chk("rm_grant_data", 32'(mem_addr), 32'h0200);
    step();
    chk("rm_d_done", 32'(d_done), 32'd1);
    d_req = 0;
    step();
    step();
    chk("rm_grant_fetch", 32'(mem_addr), 32'h0100);
    step();
    chk("rm_if_done", 32'(if_done), 32'd1);
    if_req = 0;
    step();

    // Timeout: load that never sees mem_ready.
    mem_ready = 0; d_req = 1; d_we = 0; d_addr = 16'h0300;
    step();
    cnt = 0;
    for (int k = 0; k < 40 && mem_en; k++) begin
      cnt++;
      step();
    end
    chk("to_en_cycles", cnt, 32'd15);
    chk("to_d_done", 32'(d_done), 32'd1);
    chk("to_d_rdata", d_rdata, 32'd0);
    chk("to_err", 32'(err), 32'd1);
    d_req = 0;
    step();
    chk("to_err_sticky", 32'(err), 32'd1);
    err_clr = 1;
    step();
    err_clr = 0;
    chk("to_err_clr", 32'(err), 32'd0);

    // Second abort with err_clr on the same edge: set wins.
    d_req = 1;
    step();
    repeat (14) step();
    chk("to2_mem_en_last", 32'(mem_en), 32'd1);
    err_clr = 1;
    step();
    err_clr = 0;
    chk("to2_d_done", 32'(d_done), 32'd1);
    chk("to2_err", 32'(err), 32'd1);
    d_req = 0;
    step();
    chk("to2_busy_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port data/instruction memory between the instruction-fetch requester and the load/store datapath driven by the Control_Unit's mem_write/mem_to_reg decode. Grants one access at a time, sequences each access through a three-state FSM, prevents fetch starvation under back-to-back loads/stores, and aborts hung accesses with a sticky error flag.

## Interface
Parameters:
- word_size, 32, data width
- addr_size, 16, memory address width
- max_streak, 4, consecutive data grants allowed while fetch is pending
- timeout, 15, ACCESS cycles without mem_ready before abort

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request; held with if_addr until if_done
- if_addr  in  addr_size  fetch address
- if_rdata  out  word_size  fetched word, valid while if_done=1
- if_done  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_done
- d_we  in  1  1=store, 0=load
- d_addr  in  addr_size  data address
- d_wdata  in  word_size  store data
- d_rdata  out  word_size  load data, valid while d_done=1
- d_done  out  1  one-cycle completion pulse for data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  addr_size  memory address
- mem_wdata  out  word_size  memory write data
- mem_rdata  in  word_size  memory read data, valid with mem_ready
- mem_ready  in  1  access complete (sampled only while mem_en=1)
- err  out  1  sticky timeout flag
- err_clr  in  1  clears err
- busy  out  1  high in ACCESS and RESP

## Operation
- States: IDLE, ACCESS, RESP. Owner register: FETCH or DATA.
- IDLE: if neither req, stay. If one req, grant it. If both: DATA wins unless streak==max_streak, then FETCH wins.
- Grant: load mem_addr/mem_we/mem_wdata from winner (mem_we=0, mem_wdata=0 for fetch), mem_en=1, go ACCESS.
- streak: +1 on each DATA grant made while if_req=1; saturates at max_streak; cleared on FETCH grant; unchanged otherwise.
- ACCESS: mem_ready=1 → capture mem_rdata into owner's rdata (loads/fetches only; stores leave d_rdata unchanged), mem_en=0, go RESP. Else tcnt+1; when tcnt reaches timeout-1 with no mem_ready → abort: mem_en=0, rdata=0, err=1, go RESP.
- RESP: owner's done=1 for exactly one cycle; no arbitration this cycle (requester still holding req is ignored); go IDLE.
- err: set on abort, cleared by err_clr; set wins if both same cycle.
- Requests not granted stay pending; arbiter never drops a held req.

## Timing
- Reset (rst=0, async): state IDLE, owner FETCH, streak 0, tcnt 0, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0, if_rdata 0, d_rdata 0, if_done 0, d_done 0, err 0, busy 0. Reset mid-access drops mem_en immediately; no done pulse issued.
- All outputs registered.
- Zero-wait access: req sampled in IDLE cycle N → mem_en=1 cycle N+1 → mem_ready in N+1 → done=1 cycle N+2 → IDLE N+3. Minimum 3 cycles per access.
- k wait cycles add k cycles to done.
- Timeout: mem_en high exactly timeout cycles; done in following cycle with err=1.
- mem_ready while mem_en=0 ignored.

## Structure
- Package mem_arb_pkg: arb_state_t enum {ARB_IDLE, ARB_ACCESS, ARB_RESP}, arb_owner_t enum {OWN_FETCH, OWN_DATA}.
- Sub-module arb_timeout_counter (clear, enable, terminal-count output, parameter timeout); streak counter stays inline.

## Test plan
- Lone fetch: if_req=1, if_addr=16'h0010, mem_ready same cycle as mem_en, mem_rdata=32'h98000000 → mem_en in N+1, if_done=1 in N+2 with if_rdata=32'h98000000, d_done=0.
- Store: d_req=1, d_we=1, d_addr=16'h0040, d_wdata=32'hDEADBEEF, 2 wait cycles → mem_we=1 with that addr/data for 3 cycles, d_done in N+4, d_rdata unchanged.
- Contention: if_req and d_req held continuously, max_streak=4 → grant sequence D,D,D,D,F,D,D,D,D,F.
- Timeout: d_req load, mem_ready never → mem_en high 15 cycles, d_done with d_rdata=0, err=1; err_clr pulse → err=0; err_clr coincident with second abort → err stays 1.
- Reset mid-access: rst=0 during ACCESS → mem_en, busy, done all 0 immediately; after release, held if_req granted normally, streak=0.
